// File: rtl/spi_pkg.sv
// Shared state encoding and SPI mode constants for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  // Mode encoding is {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK tick generator: one tick every CLK_DIV enabled clk cycles, with sync clear.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one DATA_W word per accepted START, selectable mode,
// NUM_CS active-low chip selects, MSB- or LSB-first shifting.
module spi_master_param #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned NUM_CS    = 1,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                                         MCLK,
  input  logic                                         RESET_N,
  input  logic                                         START,
  input  logic [DATA_W-1:0]                            DIN,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] CS_SEL,
  input  logic                                         CPOL,
  input  logic                                         CPHA,
  output logic                                         TX_RDY,
  output logic                                         BUSY,
  output logic                                         RX_VALID,
  output logic [DATA_W-1:0]                            DOUT,
  output logic                                         SCLK,
  output logic                                         MOSI,
  input  logic                                         MISO,
  output logic [NUM_CS-1:0]                            CSS_N
);

  import spi_pkg::*;

  localparam int unsigned BW = $clog2(2 * DATA_W);

  spi_state_e        state, state_nxt;
  logic              tick, accept, div_en;
  logic [DATA_W-1:0] sr, shift_in;
  logic [BW-1:0]     bit_cnt;
  logic [1:0]        mode_q;
  logic [NUM_CS-1:0] cs_mask;
  int unsigned       cs_idx;
  logic              lead, last_tick, tx_bit, first_bit;
  logic              sample_on_lead, drive_on_lead;

  assign accept    = START && TX_RDY;
  assign div_en    = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);
  assign lead      = ~bit_cnt[0];
  assign last_tick = (bit_cnt == BW'(2 * DATA_W - 1));
  assign tx_bit    = LSB_FIRST ? sr[0] : sr[DATA_W-1];
  assign first_bit = LSB_FIRST ? DIN[0] : DIN[DATA_W-1];
  assign shift_in  = LSB_FIRST ? {MISO, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], MISO};

  assign sample_on_lead = (mode_q == MODE0) || (mode_q == MODE2);
  assign drive_on_lead  = (mode_q == MODE1) || (mode_q == MODE3);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (MCLK),
    .rst_n(RESET_N),
    .en   (div_en),
    .clr  (accept),
    .tick (tick)
  );

  // Out-of-range selects fall back to chip select 0.
  always_comb begin
    cs_idx  = (32'(CS_SEL) >= NUM_CS) ? '0 : 32'(CS_SEL);
    cs_mask = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (i == cs_idx) cs_mask[i] = 1'b0;
    end
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SETUP;
      ST_SETUP: if (tick) state_nxt = ST_XFER;
      ST_XFER:  if (tick && last_tick) state_nxt = ST_HOLD;
      ST_HOLD:  if (tick) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = accept ? ST_SETUP : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A single shift register carries TX bits out and RX bits in.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      TX_RDY   <= 1'b1;
      BUSY     <= 1'b0;
      RX_VALID <= 1'b0;
      DOUT     <= '0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      CSS_N    <= '1;
      sr       <= '0;
      bit_cnt  <= '0;
      mode_q   <= '0;
    end else begin
      RX_VALID <= 1'b0;
      TX_RDY   <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
      BUSY     <= !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE));
      if (accept) begin
        sr      <= DIN;
        mode_q  <= {CPOL, CPHA};
        bit_cnt <= '0;
        SCLK    <= CPOL;
        CSS_N   <= cs_mask;
        if (!CPHA) MOSI <= first_bit;
      end else if (state == ST_IDLE) begin
        SCLK <= CPOL;
      end else if (state == ST_XFER && tick) begin
        SCLK    <= ~SCLK;
        bit_cnt <= bit_cnt + 1'b1;
        if (lead) begin
          if (sample_on_lead) sr <= shift_in;
          else                MOSI <= tx_bit;
        end else begin
          if (drive_on_lead)   sr <= shift_in;
          else if (!last_tick) MOSI <= tx_bit;
        end
      end else if (state == ST_HOLD && tick) begin
        CSS_N    <= '1;
        DOUT     <= sr;
        RX_VALID <= 1'b1;
      end
    end
  end

endmodule
